// File: rtl/seg_scan_if.sv
// Bundle between the write port / decoder / board pins and seg_scan_ctrl.
// The slave side is the scan controller; the master side is its environment.
interface seg_scan_if #(
   parameter int NDIG = 8
);
   logic            disp_en;
   logic            wr_en;
   logic [2:0]      wr_addr;
   logic [3:0]      wr_data;
   logic            upd_req;
   logic            lzb;
   logic [3:0]      dec_b;
   logic [6:0]      dec_h;
   logic [6:0]      seg;
   logic [NDIG-1:0] an;
   logic            upd_ack;
   logic            frame_done;

   modport master (
      output disp_en, wr_en, wr_addr, wr_data, upd_req, lzb, dec_h,
      input  dec_b, seg, an, upd_ack, frame_done
   );

   modport slave (
      input  disp_en, wr_en, wr_addr, wr_data, upd_req, lzb, dec_h,
      output dec_b, seg, an, upd_ack, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, NDIG anodes,
// shadow/active digit buffers committed only on a frame boundary.
module seg_scan_ctrl #(
   parameter int NDIG  = 8,
   parameter int DIV   = 1000,
   parameter int BLANK = 16
) (
   input  logic      clk,
   input  logic      rst,
   seg_scan_if.slave bus
);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int DW = $clog2(DIV);
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
   localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] BLK_LAST = DW'(BLANK - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

   state_t          state_reg, state_next;
   logic [DW-1:0]   div_cnt_reg, div_cnt_next;
   logic [IW-1:0]   idx_reg, idx_next;
   logic            pending_reg, pending_next;
   logic [3:0]      shadow_reg [NDIG];
   logic [3:0]      active_reg [NDIG];
   logic [NDIG-1:0] an_reg, an_next;
   logic [6:0]      seg_reg, seg_next;
   logic            upd_ack_reg, frame_done_reg;
   logic            boundary, commit, show_on, wr_ok;
   logic [NDIG-1:0] digit_zero, zero_from, blank_vec;

   assign boundary = (state_reg == ST_SHOW) && (idx_reg == IDX_LAST) && (div_cnt_reg == CNT_LAST);
   assign commit   = pending_reg && (boundary || (state_reg == ST_IDLE));
   assign show_on  = (state_reg == ST_SHOW) && bus.disp_en;
   assign wr_ok    = bus.wr_en && (int'(bus.wr_addr) < NDIG);

   // Leading-zero blanking: a digit goes dark when it and all higher digits are 0.
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
         assign digit_zero[gi] = (active_reg[gi] == 4'd0);
         assign an_next[gi]    = ~(show_on && (idx_reg == IW'(gi)));
         if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = bus.lzb && zero_from[gi];
         end
      end
   endgenerate

   always_comb begin
      zero_from = '0;
      zero_from[NDIG-1] = digit_zero[NDIG-1];
      for (int i = NDIG - 2; i >= 0; i--) begin
         zero_from[i] = digit_zero[i] && zero_from[i+1];
      end
   end

   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      idx_next     = idx_reg;
      case (state_reg)
         ST_IDLE: begin
            div_cnt_next = '0;
            idx_next     = '0;
            if (bus.disp_en) state_next = ST_BLANK;
         end
         ST_BLANK: begin
            div_cnt_next = div_cnt_reg + 1'b1;
            if (div_cnt_reg == BLK_LAST) state_next = ST_SHOW;
         end
         ST_SHOW: begin
            if (div_cnt_reg == CNT_LAST) begin
               div_cnt_next = '0;
               idx_next     = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
               state_next   = ST_BLANK;
            end else begin
               div_cnt_next = div_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next   = ST_IDLE;
            div_cnt_next = '0;
            idx_next     = '0;
         end
      endcase
      if (!bus.disp_en) begin
         state_next   = ST_IDLE;
         div_cnt_next = '0;
         idx_next     = '0;
      end
      // A request landing on the commit edge re-arms for the next boundary.
      pending_next = commit ? bus.upd_req : (pending_reg || bus.upd_req);
      seg_next     = 7'h7F;
      if (show_on && !blank_vec[idx_reg]) seg_next = bus.dec_h;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         div_cnt_reg    <= '0;
         idx_reg        <= '0;
         pending_reg    <= 1'b0;
         an_reg         <= '1;
         seg_reg        <= 7'h7F;
         upd_ack_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         div_cnt_reg    <= div_cnt_next;
         idx_reg        <= idx_next;
         pending_reg    <= pending_next;
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         upd_ack_reg    <= commit;
         frame_done_reg <= boundary;
      end
   end

   // Commit reads the pre-edge shadow, so a same-edge write only reaches shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NDIG; i++) begin
            shadow_reg[i] <= '0;
            active_reg[i] <= '0;
         end
      end else begin
         if (commit) begin
            for (int i = 0; i < NDIG; i++) active_reg[i] <= shadow_reg[i];
         end
         if (wr_ok) shadow_reg[bus.wr_addr[IW-1:0]] <= bus.wr_data;
      end
   end

   assign bus.dec_b      = active_reg[idx_reg];
   assign bus.an         = an_reg;
   assign bus.seg        = seg_reg;
   assign bus.upd_ack    = upd_ack_reg;
   assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIG=4, DIV=8, BLANK=2): stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_seg_scan_ctrl;
   localparam logic [6:0] OFF = 7'b1111111, ZERO = 7'b0000001, TWO = 7'b0010010;
   localparam logic [6:0] FOUR = 7'b1001100, FIVE = 7'b0100100, SEVEN = 7'b0001111;
   localparam logic [6:0] EIGHT = 7'b0000000, NINE = 7'b0001100, HEXF = 7'b0111000;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      bit         chk_seg;
      logic       ack;
      logic       fd;
      bit         chk_b;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   e0, e2, e3;
   exp_t q[$];

   seg_scan_if #(.NDIG(4)) bus ();

   seg_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External bcd7seg model: bit6 = a ... bit0 = g, active-low.
   function automatic logic [6:0] dec7(input logic [3:0] v);
      case (v)
         4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
         4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   always_comb bus.dec_h = dec7(bus.dec_b);

   task automatic push(int c, logic [3:0] an, logic [6:0] seg, bit cs,
                       logic ack, logic fd, bit cb, string nm);
      exp_t x;
      x.cyc = c; x.an = an; x.seg = seg; x.chk_seg = cs;
      x.ack = ack; x.fd = fd; x.chk_b = cb; x.name = nm;
      q.push_back(x);
   endtask

   // Samples of one frame: two dark and two lit cycles per digit slot.
   task automatic exp_frame(int e, int f, logic [6:0] s0, logic [6:0] s1,
                            logic [6:0] s2, logic [6:0] s3, logic ack, string nm);
      logic [6:0] s [4];
      int         offs [4];
      logic [3:0] a;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      offs[0] = 0; offs[1] = 1; offs[2] = 2; offs[3] = 7;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) begin
            int  p;
            bit  lit, last;
            p    = 32 * f + 8 * k + offs[j];
            lit  = (offs[j] >= 2);
            last = (k == 3) && (offs[j] == 7);
            a    = 4'hF;
            a[k] = 1'b0;
            push(e + 2 + p, lit ? a : 4'hF, s[k], lit, last ? ack : 1'b0, last,
                 1'b0, $sformatf("%s f%0d d%0d +%0d", nm, f, k, offs[j]));
         end
      end
   endtask

   task automatic goto(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(logic [2:0] a, logic [3:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic req_at(int c);
      goto(c);
      bus.upd_req = 1'b1;
      goto(c + 1);
      bus.upd_req = 1'b0;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
         total++; bad++;
         $display("FAIL %s: sample missed, now cyc %0d, required cyc %0d", q[0].name, cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         exp_t x;
         bit   ok;
         x  = q.pop_front();
         ok = (bus.an === x.an) && (bus.upd_ack === x.ack) && (bus.frame_done === x.fd);
         if (x.chk_seg && bus.seg !== x.seg) ok = 1'b0;
         if (x.chk_b && bus.dec_b !== 4'h0) ok = 1'b0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL %s cyc=%0d: got an=%b seg=%b ack=%b fd=%b dec_b=%h, want an=%b seg=%b(chk %0d) ack=%b fd=%b",
                     x.name, cyc, bus.an, bus.seg, bus.upd_ack, bus.frame_done, bus.dec_b,
                     x.an, x.seg, x.chk_seg, x.ack, x.fd);
         end
      end else begin
         if (bus.upd_ack === 1'b1) begin
            total++; bad++;
            $display("FAIL stray_ack cyc=%0d: got upd_ack=1, want 0", cyc);
         end
         if (bus.frame_done === 1'b1) begin
            total++; bad++;
            $display("FAIL stray_frame_done cyc=%0d: got frame_done=1, want 0", cyc);
         end
      end
   end

   initial begin
      bus.disp_en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.upd_req = 1'b0; bus.lzb = 1'b0;
      push(2, 4'hF, OFF, 1'b1, 1'b0, 1'b0, 1'b1, "reset");
      goto(3);
      rst = 1'b0;
      goto(5);

      // Long run: scan, commits, simultaneous events, blanking, disable mid-SHOW.
      e0 = cyc;
      exp_frame(e0, 0, ZERO, ZERO, ZERO, ZERO, 1'b0, "scan0");
      exp_frame(e0, 1, ZERO, ZERO, ZERO, ZERO, 1'b1, "hold");
      exp_frame(e0, 2, TWO, NINE, ZERO, HEXF, 1'b1, "commit1");
      exp_frame(e0, 3, TWO, NINE, ZERO, HEXF, 1'b1, "wr_on_commit");
      exp_frame(e0, 4, TWO, FOUR, ZERO, HEXF, 1'b1, "req_on_commit");
      exp_frame(e0, 5, TWO, FOUR, ZERO, HEXF, 1'b1, "lzb_nonzero");
      exp_frame(e0, 6, SEVEN, OFF, OFF, OFF, 1'b1, "lzb_0007");
      exp_frame(e0, 7, ZERO, ZERO, FIVE, OFF, 1'b0, "lzb_0500");
      push(e0 + 260, 4'b1110, ZERO, 1'b1, 1'b0, 1'b0, 1'b0, "f8 d0");
      push(e0 + 268, 4'b1101, ZERO, 1'b1, 1'b0, 1'b0, 1'b0, "f8 d1");
      push(e0 + 276, 4'b1011, FIVE, 1'b1, 1'b0, 1'b0, 1'b0, "f8 d2 a");
      push(e0 + 277, 4'b1011, FIVE, 1'b1, 1'b0, 1'b0, 1'b0, "f8 d2 b");
      push(e0 + 278, 4'hF, OFF, 1'b1, 1'b0, 1'b0, 1'b0, "disable dark");
      push(e0 + 279, 4'hF, OFF, 1'b1, 1'b0, 1'b0, 1'b0, "idle dark");
      push(e0 + 281, 4'hF, OFF, 1'b1, 1'b1, 1'b0, 1'b0, "idle commit");
      bus.disp_en = 1'b1;

      goto(e0 + 10);
      wr(3'd3, 4'hF); wr(3'd2, 4'h0); wr(3'd1, 4'h9); wr(3'd0, 4'h2);
      wr(3'd5, 4'h7);
      req_at(e0 + 45);
      req_at(e0 + 70);
      req_at(e0 + 75);
      goto(e0 + 96);
      wr(3'd1, 4'h4);
      req_at(e0 + 110);
      req_at(e0 + 128);
      goto(e0 + 163);
      bus.lzb = 1'b1;
      goto(e0 + 165);
      wr(3'd3, 4'h0); wr(3'd2, 4'h0); wr(3'd1, 4'h0); wr(3'd0, 4'h7);
      req_at(e0 + 175);
      goto(e0 + 200);
      wr(3'd3, 4'h0); wr(3'd2, 4'h5); wr(3'd1, 4'h0); wr(3'd0, 4'h0);
      req_at(e0 + 210);
      goto(e0 + 277);
      bus.disp_en = 1'b0;
      goto(e0 + 278);
      wr(3'd0, 4'h8);
      req_at(e0 + 279);

      // Re-enable restarts at digit 0; then reset mid-SHOW with a commit pending.
      goto(e0 + 284);
      e2 = cyc;
      exp_frame(e2, 0, EIGHT, ZERO, FIVE, OFF, 1'b0, "restart");
      push(e2 + 46, 4'hF, OFF, 1'b1, 1'b0, 1'b0, 1'b1, "rst mid show");
      bus.disp_en = 1'b1;
      req_at(e2 + 40);
      goto(e2 + 45);
      rst = 1'b1; bus.disp_en = 1'b0; bus.lzb = 1'b0;
      goto(e2 + 47);
      rst = 1'b0;

      goto(e2 + 50);
      e3 = cyc;
      exp_frame(e3, 0, ZERO, ZERO, ZERO, ZERO, 1'b0, "post_rst");
      exp_frame(e3, 1, ZERO, ZERO, ZERO, ZERO, 1'b1, "post_rst req");
      exp_frame(e3, 2, ZERO, ZERO, ZERO, ZERO, 1'b0, "shadow_lost");
      bus.disp_en = 1'b1;
      req_at(e3 + 45);
      goto(e3 + 2 + 95 + 3);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
